// File: rtl/seq_det_ctrl.sv
// Round-robin front end that serialises a latched 8-bit word, MSB first, into an
// external 3-ones Moore detector and counts the detector hits for that word.
module seq_det_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       done,
    output logic       owner,
    output logic [3:0] cnt,
    output logic       det_rst,
    output logic       det_x,
    input  logic       det_y
);

    // state | meaning
    // IDLE  | waiting for a request; detector out of reset, det_x low
    // CLR   | grant pulse, detector held in reset
    // SHIFT | eight cycles driving word[7-idx] onto det_x
    // DRAIN | det_x low, collects the detector result for the last bit
    // DONE  | done pulse, cnt/owner valid
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] word, word_nx;
    logic       last, last_nx;
    logic       armed;
    logic       winner;
    logic [3:0] cnt_inc;

    logic [1:0] gnt_nx;
    logic       done_nx;
    logic       owner_nx;
    logic [3:0] cnt_nx;
    logic       det_rst_nx;
    logic       det_x_nx;

    // armed holds off acceptance for one edge after reset so the detector
    // always sees det_rst released on the first clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 3'd0;
            word    <= 8'h00;
            last    <= 1'b1;
            armed   <= 1'b0;
            gnt     <= 2'b00;
            done    <= 1'b0;
            owner   <= 1'b0;
            cnt     <= 4'd0;
            det_rst <= 1'b0;
            det_x   <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            word    <= word_nx;
            last    <= last_nx;
            armed   <= 1'b1;
            gnt     <= gnt_nx;
            done    <= done_nx;
            owner   <= owner_nx;
            cnt     <= cnt_nx;
            det_rst <= det_rst_nx;
            det_x   <= det_x_nx;
        end
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        word_nx    = word;
        last_nx    = last;
        owner_nx   = owner;
        cnt_nx     = cnt;
        gnt_nx     = 2'b00;
        done_nx    = 1'b0;
        det_rst_nx = 1'b1;
        det_x_nx   = 1'b0;
        winner     = (req == 2'b11) ? ~last : req[1];

        case (state)
            IDLE: begin
                if (armed && (req != 2'b00)) begin
                    state_nx   = CLR;
                    word_nx    = winner ? data1 : data0;
                    owner_nx   = winner;
                    last_nx    = winner;
                    cnt_nx     = 4'd0;
                    gnt_nx     = winner ? 2'b10 : 2'b01;
                    det_rst_nx = 1'b0;
                end
            end
            CLR: begin
                state_nx = SHIFT;
                idx_nx   = 3'd0;
                det_x_nx = word[7];
            end
            SHIFT: begin
                // det_y in cycle idx reflects bit idx-1; cycle 0 only sees the cleared detector
                if ((idx != 3'd0) && det_y) begin
                    cnt_nx = cnt_inc;
                end
                if (idx == 3'd7) begin
                    state_nx = DRAIN;
                end else begin
                    idx_nx   = idx + 3'd1;
                    det_x_nx = word[3'd6 - idx];
                end
            end
            DRAIN: begin
                if (det_y) begin
                    cnt_nx = cnt_inc;
                end
                state_nx = DONE;
                done_nx  = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a behavioural 3-ones detector in the loop.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [1:0] gnt;
    logic       done;
    logic       owner;
    logic [3:0] cnt;
    logic       det_rst;
    logic       det_x;
    logic       det_y;
    logic       det_y_force = 1'b0;
    logic [1:0] det_s = 2'b00;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data0   (data0),
        .data1   (data1),
        .gnt     (gnt),
        .done    (done),
        .owner   (owner),
        .cnt     (cnt),
        .det_rst (det_rst),
        .det_x   (det_x),
        .det_y   (det_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external detector: 00-1->01-1->11-1->10-1->10, any 0 -> 00
    always @(posedge clk or negedge det_rst) begin
        if (!det_rst) det_s <= 2'b00;
        else if (!det_x) det_s <= 2'b00;
        else begin
            case (det_s)
                2'b00:   det_s <= 2'b01;
                2'b01:   det_s <= 2'b11;
                default: det_s <= 2'b10;
            endcase
        end
    end

    assign det_y = (det_s == 2'b10) | det_y_force;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] egnt;
        logic       eown;
        int         ecnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g, output int at);
        logic got;
        got = 1'b0;
        g   = 2'b00;
        at  = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00) begin
                got = 1'b1;
                g   = gnt;
                at  = cyc;
            end
        end
        check("gnt_seen", int'(got), 1);
    endtask

    task automatic wait_done(output int at);
        logic got;
        got = 1'b0;
        at  = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        check("done_seen", int'(got), 1);
    endtask

    task automatic run_txn(input vec_t v);
        logic [7:0] w;
        int         edges;
        logic       got;
        w     = v.eown ? v.d1 : v.d0;
        req   = v.req;
        data0 = v.d0;
        data1 = v.d1;
        got   = 1'b0;
        edges = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(posedge clk); #1;
            edges++;
            if (gnt != 2'b00) got = 1'b1;
        end
        check("gnt_seen", int'(got), 1);
        if (!got) begin
            req = 2'b00;
            return;
        end
        check("gnt_latency", edges, 1);
        check("gnt_value", gnt, v.egnt);
        check("owner_at_gnt", owner, v.eown);
        check("cnt_clr_at_gnt", cnt, 0);
        check("det_rst_clr", det_rst, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("det_x_shift", det_x, w[7-k]);
            check("det_rst_shift", det_rst, 1);
            if (k == 0) check("gnt_pulse", gnt, 0);
        end
        @(posedge clk); #1;
        check("det_x_drain", det_x, 0);
        check("done_early", done, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("cnt_value", cnt, v.ecnt);
        check("owner_value", owner, v.eown);
        req = 2'b00;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("cnt_hold", cnt, v.ecnt);
        check("owner_hold", owner, v.eown);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        int         t1, t2, t3, td;

        vecs[0] = '{2'b01, 8'hFF, 8'h00, 2'b01, 1'b0, 6};
        vecs[1] = '{2'b10, 8'h00, 8'b01110111, 2'b10, 1'b1, 2};
        vecs[2] = '{2'b10, 8'h00, 8'b11011011, 2'b10, 1'b1, 0};
        vecs[3] = '{2'b01, 8'hE0, 8'h00, 2'b01, 1'b0, 1};
        vecs[4] = '{2'b10, 8'h00, 8'h07, 2'b10, 1'b1, 1};
        vecs[5] = '{2'b01, 8'h00, 8'hFF, 2'b01, 1'b0, 0};
        vecs[6] = '{2'b01, 8'h7F, 8'h00, 2'b01, 1'b0, 5};
        vecs[7] = '{2'b01, 8'hF0, 8'h00, 2'b01, 1'b0, 2};
        vecs[8] = '{2'b01, 8'hBD, 8'h00, 2'b01, 1'b0, 2};
        vecs[9] = '{2'b10, 8'h00, 8'hFE, 2'b10, 1'b1, 5};

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cnt, 0);
        check("rst_owner", owner, 0);
        check("rst_det_x", det_x, 0);
        check("rst_det_rst", det_rst, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("det_rst_release", det_rst, 1);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // detector output must not move cnt while idle
        det_y_force = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_det_y_cnt", cnt, 5);
        check("idle_det_y_done", done, 0);
        det_y_force = 1'b0;

        // mid-flight data change and late request from requester 1
        data0 = 8'hFF;
        req   = 2'b01;
        wait_gnt(g, t1);
        check("mid_gnt", g, 2'b01);
        repeat (3) @(posedge clk);
        #1;
        data0 = 8'h00;
        data1 = 8'h07;
        req   = 2'b11;
        wait_done(td);
        check("mid_cnt", cnt, 6);
        check("mid_owner", owner, 0);
        req = 2'b10;
        wait_gnt(g, t2);
        check("late_gnt", g, 2'b10);
        check("late_gnt_gap", t2 - td, 2);
        wait_done(td);
        check("late_cnt", cnt, 1);
        check("late_owner", owner, 1);
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // reset during SHIFT cycle 4; last served is now requester 1 then 0
        data0 = 8'hFF;
        req   = 2'b01;
        wait_gnt(g, t1);
        check("rstmid_gnt", g, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_in_shift", det_rst, 1);
        rst = 1'b0;
        #1;
        check("rstmid_gnt0", gnt, 0);
        check("rstmid_done0", done, 0);
        check("rstmid_cnt0", cnt, 0);
        check("rstmid_owner0", owner, 0);
        check("rstmid_det_x0", det_x, 0);
        check("rstmid_det_rst0", det_rst, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("rstmid_no_done", done, 0);
            check("rstmid_det_rst_low", det_rst, 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_det_rst_up", det_rst, 1);
        check("rstmid_no_done_after", done, 0);
        wait_gnt(g, t1);
        check("rstmid_regnt", g, 2'b01);
        wait_done(td);
        check("rstmid_done_lat", td - t1, 10);
        check("rstmid_cnt", cnt, 6);
        req = 2'b00;

        // tie arbitration after reset: previous grant was requester 0
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        data0 = 8'hE0;
        data1 = 8'h07;
        req   = 2'b11;
        wait_gnt(g, t1);
        check("tie_gnt1", g, 2'b01);
        wait_done(td);
        check("tie_cnt1", cnt, 1);
        check("tie_owner1", owner, 0);
        wait_gnt(g, t2);
        check("tie_gnt2", g, 2'b10);
        check("tie_gap12", t2 - t1, 12);
        wait_done(td);
        check("tie_cnt2", cnt, 1);
        check("tie_owner2", owner, 1);
        wait_gnt(g, t3);
        check("tie_gnt3", g, 2'b01);
        check("tie_gap23", t3 - t2, 12);
        wait_done(td);
        check("tie_cnt3", cnt, 1);
        req = 2'b00;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
